// File: rtl/mem_loader.sv
// Byte-stream memory loader: packs little-endian bytes into DATA_WIDTH words and
// writes them to consecutive (wrapping) addresses, keeping a mod-256 byte checksum.
module mem_loader #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  we,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            checksum
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    if ((DATA_WIDTH == 0) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
        $error("mem_loader: DATA_WIDTH must be a non-zero multiple of 8");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic [IDX_W-1:0]      idx_q,       idx_d;
    logic [DATA_WIDTH-1:0] word_q,      word_d;
    logic [7:0]            checksum_d;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  in_ready_d;
    logic                  we_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  accept;

    // in_ready is a flop that mirrors state==COLLECT, so this has no input-to-output path
    assign accept = in_valid & in_ready;

    // State and datapath registers; outputs are flopped from their next-state decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            checksum    <= '0;
            waddr       <= '0;
            wdata       <= '0;
            in_ready    <= 1'b0;
            we          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            checksum    <= checksum_d;
            waddr       <= waddr_d;
            wdata       <= wdata_d;
            in_ready    <= in_ready_d;
            we          <= we_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        word_d      = word_q;
        checksum_d  = checksum;
        waddr_d     = waddr;
        wdata_d     = wdata;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = start_addr;
                    remaining_d = len;
                    idx_d       = '0;
                    word_d      = '0;
                    checksum_d  = '0;
                    state_d     = (len == '0) ? DONE : COLLECT;
                end
            end

            COLLECT: begin
                if (accept) begin
                    for (int b = 0; b < int'(BYTES); b++) begin
                        if (idx_q == IDX_W'(b)) begin
                            word_d[b*8 +: 8] = in_data;
                        end
                    end
                    checksum_d = checksum + in_data;
                    if (idx_q == IDX_W'(BYTES - 1)) begin
                        // Word complete: present it on the write port next cycle
                        idx_d   = '0;
                        waddr_d = addr_q;
                        wdata_d = word_d;
                        state_d = WRITE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            WRITE: begin
                addr_d      = addr_q + ADDR_WIDTH'(1);
                remaining_d = remaining_q - CNT_W'(1);
                idx_d       = '0;
                state_d     = (remaining_q == CNT_W'(1)) ? DONE : COLLECT;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == COLLECT);
        we_d       = (state_d == WRITE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: an 8-bit-word and a 16-bit-word instance,
// directed loads push expected writes/checksums, per-instance monitors pop and compare.
module tb_mem_loader;

    localparam int unsigned AW    = 9;
    localparam int unsigned LW    = AW + 1;
    localparam int          DEPTH = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: 8-bit words
    logic          start_a;
    logic [AW-1:0] sa_a;
    logic [AW:0]   len_a;
    logic [7:0]    din_a;
    logic          vld_a;
    logic          rdy_a;
    logic [AW-1:0] waddr_a;
    logic [7:0]    wdata_a;
    logic          we_a, busy_a, done_a;
    logic [7:0]    cs_a;

    // Instance B: 16-bit words
    logic          start_b;
    logic [AW-1:0] sa_b;
    logic [AW:0]   len_b;
    logic [7:0]    din_b;
    logic          vld_b;
    logic          rdy_b;
    logic [AW-1:0] waddr_b;
    logic [15:0]   wdata_b;
    logic          we_b, busy_b, done_b;
    logic [7:0]    cs_b;

    mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .start_addr(sa_a), .len(len_a),
        .in_data(din_a), .in_valid(vld_a), .in_ready(rdy_a),
        .waddr(waddr_a), .wdata(wdata_a), .we(we_a),
        .busy(busy_a), .done(done_a), .checksum(cs_a)
    );

    mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .start_addr(sa_b), .len(len_b),
        .in_data(din_b), .in_valid(vld_b), .in_ready(rdy_b),
        .waddr(waddr_b), .wdata(wdata_b), .we(we_b),
        .busy(busy_b), .done(done_b), .checksum(cs_b)
    );

    int         vectors = 0;
    int         errors  = 0;
    int         cyc     = 0;
    wr_t        exp_wr_a[$];
    wr_t        exp_wr_b[$];
    logic [7:0] exp_cs_a[$];
    logic [7:0] exp_cs_b[$];
    int         we_times_a[$];
    logic [7:0] src_a[$];
    logic [7:0] src_b[$];
    wr_t        e_a, e_b;
    logic [7:0] c_a, c_b;
    int         gaps[6] = '{0, 2, 0, 1, 3, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor A
    always @(negedge clk) begin
        if (!rst) begin
            if (we_a) begin
                we_times_a.push_back(cyc);
                if (exp_wr_a.size() == 0) begin
                    check("a_unexpected_we", 32'(waddr_a), 32'hFFFF_FFFF);
                end else begin
                    e_a = exp_wr_a.pop_front();
                    check("a_waddr", 32'(waddr_a), 32'(e_a.a));
                    check("a_wdata", 32'(wdata_a), 32'(e_a.d));
                end
            end
            if (done_a) begin
                if (exp_cs_a.size() == 0) begin
                    check("a_unexpected_done", 32'(done_a), 32'd0);
                end else begin
                    c_a = exp_cs_a.pop_front();
                    check("a_checksum", 32'(cs_a), 32'(c_a));
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (!rst) begin
            if (we_b) begin
                if (exp_wr_b.size() == 0) begin
                    check("b_unexpected_we", 32'(waddr_b), 32'hFFFF_FFFF);
                end else begin
                    e_b = exp_wr_b.pop_front();
                    check("b_waddr", 32'(waddr_b), 32'(e_b.a));
                    check("b_wdata", 32'(wdata_b), 32'(e_b.d));
                end
            end
            if (done_b) begin
                if (exp_cs_b.size() == 0) begin
                    check("b_unexpected_done", 32'(done_b), 32'd0);
                end else begin
                    c_b = exp_cs_b.pop_front();
                    check("b_checksum", 32'(cs_b), 32'(c_b));
                end
            end
        end
    end

    // All drivers start and end at #1 after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        bit acc = 1'b0;
        int t   = 0;
        vld_a = 1'b1;
        din_a = b;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = rdy_a;
            tick();
            t++;
        end
        vld_a = 1'b0;
        if (!acc) check("a_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_b(input logic [7:0] b, input int gap);
        bit acc = 1'b0;
        int t   = 0;
        vld_b = 1'b0;
        repeat (gap) tick();
        vld_b = 1'b1;
        din_b = b;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = rdy_b;
            tick();
            t++;
        end
        vld_b = 1'b0;
        if (!acc) check("b_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done_a();
        int t = 0;
        while (!done_a && t < 50) begin
            tick();
            t++;
        end
        if (!done_a) check("a_done_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_done_b();
        int t = 0;
        while (!done_b && t < 50) begin
            tick();
            t++;
        end
        if (!done_b) check("b_done_timeout", 32'd0, 32'd1);
        tick();
    endtask

    // Load src_a (one byte per word) into instance A
    task automatic load_a(input logic [AW-1:0] sa, input int l);
        wr_t        ew;
        logic [7:0] s = 8'h00;
        for (int k = 0; k < l; k++) begin
            ew.a = AW'(int'(sa) + k);
            ew.d = 16'(src_a[k]);
            exp_wr_a.push_back(ew);
            s = s + src_a[k];
        end
        exp_cs_a.push_back(s);
        start_a = 1'b1;
        sa_a    = sa;
        len_a   = LW'(l);
        tick();
        start_a = 1'b0;
        check("a_cs_cleared", 32'(cs_a), 32'd0);
        check("a_ready_after_start", 32'(rdy_a), 32'd1);
        for (int k = 0; k < l; k++) send_a(src_a[k]);
        wait_done_a();
    endtask

    // Load src_b (two bytes per word, little-endian) into instance B
    task automatic load_b(input logic [AW-1:0] sa, input int l, input bit stall, input bit poke);
        wr_t        ew;
        logic [7:0] s = 8'h00;
        for (int k = 0; k < l; k++) begin
            ew.a = AW'(int'(sa) + k);
            ew.d = {src_b[2*k+1], src_b[2*k]};
            exp_wr_b.push_back(ew);
        end
        for (int k = 0; k < 2*l; k++) s = s + src_b[k];
        exp_cs_b.push_back(s);
        start_b = 1'b1;
        sa_b    = sa;
        len_b   = LW'(l);
        tick();
        start_b = 1'b0;
        check("b_ready_after_start", 32'(rdy_b), 32'd1);
        for (int k = 0; k < 2*l; k++) begin
            if (poke && k == 1) begin
                start_b = 1'b1;
                sa_b    = 9'h0AA;
                len_b   = 10'd1;
                tick();
                start_b = 1'b0;
            end
            send_b(src_b[k], stall ? gaps[k % 6] : 0);
        end
        wait_done_b();
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0; sa_a = '0; len_a = '0; din_a = '0; vld_a = 1'b0;
        start_b = 1'b0; sa_b = '0; len_b = '0; din_b = '0; vld_b = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        check("a_reset_outs", 32'({rdy_a, waddr_a, wdata_a, we_a, busy_a, done_a, cs_a}), 32'd0);
        check("b_reset_outs", {rdy_b, waddr_b[6:0], wdata_b, we_b, busy_b, done_b, cs_b[3:0]}, 32'd0);
        check("b_reset_cs_hi", 32'({waddr_b[8:7], cs_b[7:4]}), 32'd0);

        // Basic 8-bit load, back-to-back bytes, 2 cycles per word
        src_a = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        we_times_a.delete();
        load_a(9'h010, 4);
        check("a_we_count", 32'(we_times_a.size()), 32'd4);
        for (int i = 1; i < we_times_a.size(); i++)
            check("a_we_spacing", 32'(we_times_a[i] - we_times_a[i-1]), 32'd2);
        check("a_cs_basic", 32'(cs_a), 32'h8A);

        // Back-to-back: start in the cycle right after done
        src_a = '{8'h10, 8'h20};
        load_a(9'h1F0, 2);
        check("a_cs_b2b", 32'(cs_a), 32'h30);

        // 16-bit packing with address wrap
        src_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        load_b(9'h1FE, 3, 1'b0, 1'b0);
        repeat (3) tick();
        check("b_cs_hold", 32'(cs_b), 32'h15);
        check("b_idle_busy", 32'(busy_b), 32'd0);

        // Same load with valid gaps and a start pulse while busy
        load_b(9'h1FE, 3, 1'b1, 1'b1);

        // len == 0: done one cycle after start, no write
        exp_cs_b.push_back(8'h00);
        start_b = 1'b1;
        sa_b    = 9'h123;
        len_b   = 10'd0;
        tick();
        start_b = 1'b0;
        check("b_len0_done", 32'(done_b), 32'd1);
        check("b_len0_ready", 32'(rdy_b), 32'd0);
        tick();
        tick();
        check("b_len0_idle", 32'(busy_b), 32'd0);

        // len = DEPTH+1 on 8-bit: wraps, last write lands on start_addr
        src_a.delete();
        for (int i = 0; i <= DEPTH; i++) src_a.push_back(8'(i));
        load_a(9'h055, DEPTH + 1);

        // Reset mid-COLLECT: partial word discarded, no write, no done
        src_b = '{8'h77, 8'h88};
        start_b = 1'b1;
        sa_b    = 9'h100;
        len_b   = 10'd2;
        tick();
        start_b = 1'b0;
        send_b(8'h77, 0);
        rst = 1'b1;
        #1;
        check("b_rst_mid_outs", {rdy_b, we_b, busy_b, done_b, cs_b, wdata_b}, 32'd0);
        check("b_rst_mid_addr", 32'(waddr_b), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        vld_b = 1'b1;
        din_b = 8'h99;
        repeat (4) tick();
        vld_b = 1'b0;
        check("b_rst_idle", 32'({busy_b, rdy_b, cs_b}), 32'd0);

        repeat (3) tick();
        check("a_pending_wr", 32'(exp_wr_a.size()), 32'd0);
        check("a_pending_done", 32'(exp_cs_a.size()), 32'd0);
        check("b_pending_wr", 32'(exp_wr_b.size()), 32'd0);
        check("b_pending_done", 32'(exp_cs_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
# mem_loader

Write-side companion to the synchronous ROM/RAM primitives: accepts a byte stream over a valid/ready handshake and packs it into DATA_WIDTH words. It writes those words to consecutive addresses through a single-port memory write interface (waddr/wdata/we). It sits between a byte source (UART/SPI receiver, host bridge) and a RAM that is later read like the ROM, so memory contents can be loaded at run time instead of via init files. A running byte checksum is kept for host-side verification.

## Interface
Parameters:
- ADDR_WIDTH, 9, memory address width; DEPTH = 1 << ADDR_WIDTH
- DATA_WIDTH, 8, memory word width; must be a multiple of 8; BYTES = DATA_WIDTH / 8

Ports:
- clk  input  1  sole clock, all logic on posedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a load; honoured only in IDLE
- start_addr  input  ADDR_WIDTH  first word address, sampled on accepted start
- len  input  ADDR_WIDTH+1  number of words to write, sampled on accepted start
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a byte this cycle
- waddr  output  ADDR_WIDTH  memory write address
- wdata  output  DATA_WIDTH  memory write data
- we  output  1  memory write strobe, one cycle per word
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at end of load
- checksum  output  8  mod-256 sum of bytes accepted in current/last load

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: in_ready=0, we=0. On start=1: latch addr<=start_addr, remaining<=len, byte index<=0, checksum<=0. Go to DONE if len==0, else COLLECT. start in any other state is ignored.
- COLLECT: in_ready=1. Byte accepted when in_valid & in_ready.
  - Byte k of a word (k = 0..BYTES-1) goes to bits [8k+7:8k], i.e. little-endian, first byte in the LSBs.
  - checksum <= checksum + in_data, 8-bit wrap.
  - On acceptance of byte BYTES-1, next state is WRITE.
- WRITE: in_ready=0. we=1, waddr=addr, wdata=assembled word, all for exactly this cycle.
  - Then addr <= addr+1, wrapping modulo DEPTH (DEPTH-1 -> 0).
  - Then remaining <= remaining-1, and byte index <= 0.
  - Next state is DONE if remaining was 1, else COLLECT.
- DONE: done=1 for this cycle, busy=1; next state IDLE.
- len > DEPTH is legal; addresses wrap and earlier words are overwritten in order.
- in_valid while in_ready=0 is not consumed; the source holds the byte.
- checksum holds its value after DONE until the next accepted start.

## Timing
- Reset values: in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, checksum=0, state=IDLE, internal counters 0.
- Reset asserted mid-load aborts immediately. No further we pulse occurs, no done pulse occurs, and partial words are discarded.
- we, waddr, wdata, done, busy and in_ready are all registered outputs (state-decoded from registers); no combinational path from inputs.
- Cycle of start -> first cycle with in_ready=1: 1.
- Per word with in_valid held high: BYTES accept cycles, then 1 WRITE cycle. Sustained rate is BYTES+1 cycles per word.
- Acceptance of the final byte of the final word -> we: 1 cycle later. we -> done: 1 cycle. done -> IDLE (new start accepted): the next cycle.
- len==0: done pulses 1 cycle after start, with no we and checksum=0.
- Gaps in in_valid stall COLLECT indefinitely; there is no timeout.

## Test plan
- Reset check: hold rst high, then release -> all outputs 0, in_ready=0. Assert rst mid-COLLECT -> outputs return to 0 and no we occurs.
- Basic load, DATA_WIDTH=8: start_addr=0x010, len=4, bytes 0xA1..0xA4 streamed back-to-back -> we at 0x010..0x013 with 0xA1..0xA4, 2 cycles between we pulses, done once, checksum=0x8A.
- Packing and wrap, DATA_WIDTH=16, ADDR_WIDTH=9: start_addr=0x1FE, len=3, bytes 0x01..0x06 -> writes 0x1FE=0x0201, 0x1FF=0x0403, 0x000=0x0605, then done, checksum=0x15.
- Backpressure/stall: randomly deassert in_valid during the test above -> identical writes and checksum. No byte is accepted while in_ready=0 during WRITE, and no duplicate or dropped bytes.
- Boundary cases: len=0 -> done 1 cycle after start, we never asserted. A start pulse while busy -> ignored, with the load continuing at its original addresses. len=DEPTH+1 with DATA_WIDTH=8 -> the final write lands on start_addr again.
- Back-to-back loads: issue start in the cycle after done -> accepted, checksum cleared, and the second load writes correctly.
